// File: rtl/condition_flag_unit.sv
// rtl/condition_flag_unit.sv - architectural condition flags with in-flight setter tracking and forwarding
//
// Purpose: holds nz/ez/lz/gz/le/ge derived from the signed ALU writeback result,
// counts flag-setting instructions between decode and writeback, and tells the
// branch decoder whether the flags it sees are valid (forwarding the same-cycle
// writeback when it is the last outstanding setter) or whether it must stall.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   issue_setflags        decode issued a flag-setting instruction this cycle
//   wb_valid, wb_setflags writeback holds a valid, flag-updating result
//   wb_result             signed writeback result
//   flush                 squash all younger in-flight flag setters
//   br_query              decode holds a conditional branch needing flags
//   nz, ez, lz, gz, le, ge flags for the branch decoder
//   flags_ready, stall    flag validity for the querying branch / stall request
//   pending               in-flight flag-setter count
//   err                   sticky protocol error
module condition_flag_unit #(
  parameter int DATA_W       = 36,
  parameter int MAX_INFLIGHT = 3,
  localparam int PW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_setflags,
  input  logic              wb_valid,
  input  logic              wb_setflags,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              flush,
  input  logic              br_query,
  output logic              nz,
  output logic              ez,
  output logic              lz,
  output logic              gz,
  output logic              le,
  output logic              ge,
  output logic              flags_ready,
  output logic              stall,
  output logic [PW-1:0]     pending,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [PW-1:0] CNT_ZERO = '0;
  localparam logic [PW-1:0] CNT_ONE  = PW'(1);
  localparam logic [PW-1:0] CNT_MAX  = PW'(MAX_INFLIGHT);

  // Flag vector order: {nz, ez, lz, gz, le, ge}
  localparam logic [5:0] FLAGS_OF_ZERO = 6'b010011;

  function automatic logic [5:0] derive_flags(input logic [DATA_W-1:0] r);
    logic f_ez, f_nz, f_lz, f_gz, f_le, f_ge;
    f_ez = (r == '0);
    f_nz = ~f_ez;
    f_lz = r[DATA_W-1];
    f_gz = ~f_lz & f_nz;
    f_le = f_lz | f_ez;
    f_ge = ~f_lz;
    return {f_nz, f_ez, f_lz, f_gz, f_le, f_ge};
  endfunction

  logic [5:0]    flag_reg;
  logic [5:0]    wb_flags;
  logic [5:0]    flags_out;
  logic [PW-1:0] pending_q;
  logic [PW-1:0] pending_d;
  logic          err_q;
  logic          err_d;
  logic          wb_fire;
  logic          forward;
  state_t        state;

  assign wb_fire  = wb_valid & wb_setflags;
  assign wb_flags = derive_flags(wb_result);

  // The state is a view of the counter; it exists to name the boundary cases.
  always_comb begin
    state = ST_PENDING;
    if (pending_q == CNT_ZERO) begin
      state = ST_IDLE;
    end else if (pending_q == CNT_MAX) begin
      state = ST_FULL;
    end
  end

  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (flush) begin
      pending_d = CNT_ZERO;
    end else if (issue_setflags && !wb_fire) begin
      if (state == ST_FULL) begin
        err_d = 1'b1;                // saturate rather than wrap
      end else begin
        pending_d = pending_q + CNT_ONE;
      end
    end else if (wb_fire && !issue_setflags) begin
      if (state != ST_IDLE) begin
        pending_d = pending_q - CNT_ONE;
      end
    end
    // A flag writeback with nothing outstanding is an orphan, flushed or not.
    if (wb_fire && !issue_setflags && state == ST_IDLE) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg  <= FLAGS_OF_ZERO;
      pending_q <= CNT_ZERO;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
      // Writebacks in a flush cycle belong to older instructions and still land.
      if (wb_fire) begin
        flag_reg <= wb_flags;
      end
    end
  end

  // Only the last outstanding setter may be forwarded; with two or more in
  // flight a younger setter will overwrite the flags later.
  assign forward     = (pending_q == CNT_ONE) & wb_fire;
  assign flags_ready = (pending_q == CNT_ZERO) | forward;
  assign stall       = br_query & ~flags_ready;
  assign flags_out   = forward ? wb_flags : flag_reg;

  assign {nz, ez, lz, gz, le, ge} = flags_out;
  assign pending = pending_q;
  assign err     = err_q;

endmodule

// File: tb/tb_condition_flag_unit.sv
// tb/tb_condition_flag_unit.sv - self-checking bench for condition_flag_unit
module tb_condition_flag_unit;

  logic        clk;
  logic        rst_n;
  logic        issue_setflags;
  logic        wb_valid;
  logic        wb_setflags;
  logic [35:0] wb_result;
  logic        flush;
  logic        br_query;
  logic        nz, ez, lz, gz, le, ge;
  logic        flags_ready;
  logic        stall;
  logic [1:0]  pending;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // Observed/expected vector: {nz,ez,lz,gz,le,ge, flags_ready, stall, pending[1:0], err}
  logic [10:0] exp_q[$];

  typedef struct {
    logic        iss;
    logic        wbv;
    logic [35:0] res;
    logic        fl;
    logic        br;
    logic [10:0] exp;
  } step_t;

  condition_flag_unit #(.DATA_W(36), .MAX_INFLIGHT(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_setflags (issue_setflags),
    .wb_valid       (wb_valid),
    .wb_setflags    (wb_setflags),
    .wb_result      (wb_result),
    .flush          (flush),
    .br_query       (br_query),
    .nz             (nz),
    .ez             (ez),
    .lz             (lz),
    .gz             (gz),
    .le             (le),
    .ge             (ge),
    .flags_ready    (flags_ready),
    .stall          (stall),
    .pending        (pending),
    .err            (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] fl_of(input logic [35:0] r);
    logic e, n, l;
    e = (r == 36'h0);
    n = !e;
    l = r[35];
    return {n, e, l, (!l && n), (l || e), !l};
  endfunction

  function automatic logic [10:0] ev(input logic [5:0] f, input logic rdy,
                                     input logic st, input logic [1:0] p, input logic e);
    return {f, rdy, st, p, e};
  endfunction

  function automatic step_t mk(input logic iss, input logic wbv, input logic [35:0] res,
                               input logic fl, input logic br, input logic [10:0] exp);
    step_t s;
    s.iss = iss; s.wbv = wbv; s.res = res; s.fl = fl; s.br = br; s.exp = exp;
    return s;
  endfunction

  function automatic logic [10:0] observed();
    return {nz, ez, lz, gz, le, ge, flags_ready, stall, pending, err};
  endfunction

  task automatic drive(input step_t s);
    issue_setflags = s.iss;
    wb_valid       = s.wbv;
    wb_setflags    = s.wbv;
    wb_result      = s.res;
    flush          = s.fl;
    br_query       = s.br;
  endtask

  task automatic idle_inputs();
    issue_setflags = 1'b0;
    wb_valid       = 1'b0;
    wb_setflags    = 1'b0;
    wb_result      = 36'h0;
    flush          = 1'b0;
    br_query       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] got, want;
    do_reset();
    br_query = 1'b1;
    exp_q.push_back(ev(fl_of(36'h0), 1'b1, 1'b0, 2'd0, 1'b0));
    @(negedge clk);
    got = observed();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", got, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_forward();
    step_t s[$];
    logic [10:0] got, want;
    s.push_back(mk(1, 0, 36'h0, 0, 1, ev(fl_of(36'h0), 1, 0, 2'd0, 0)));
    s.push_back(mk(0, 0, 36'h0, 0, 1, ev(fl_of(36'h0), 0, 1, 2'd1, 0)));
    s.push_back(mk(0, 1, 36'h0_0000_0005, 0, 1, ev(fl_of(36'h5), 1, 0, 2'd1, 0)));
    s.push_back(mk(0, 0, 36'h0, 0, 1, ev(fl_of(36'h5), 1, 0, 2'd0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL single_forward step=%0d got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    logic [10:0] got, want;
    s.push_back(mk(1, 0, 36'h0, 0, 1, ev(fl_of(36'h5), 1, 0, 2'd0, 0)));
    s.push_back(mk(1, 0, 36'h0, 0, 1, ev(fl_of(36'h5), 0, 1, 2'd1, 0)));
    s.push_back(mk(0, 1, 36'hF_FFFF_FFFF, 0, 1, ev(fl_of(36'h5), 0, 1, 2'd2, 0)));
    s.push_back(mk(0, 1, 36'h0, 0, 1, ev(fl_of(36'h0), 1, 0, 2'd1, 0)));
    s.push_back(mk(0, 0, 36'h0, 0, 1, ev(fl_of(36'h0), 1, 0, 2'd0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back step=%0d got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_issue_with_wb();
    step_t s[$];
    logic [10:0] got, want;
    s.push_back(mk(1, 0, 36'h0, 0, 1, ev(fl_of(36'h0), 1, 0, 2'd0, 0)));
    s.push_back(mk(1, 1, 36'h8_0000_0000, 0, 1, ev(fl_of(36'h8_0000_0000), 1, 0, 2'd1, 0)));
    s.push_back(mk(0, 0, 36'h0, 0, 1, ev(fl_of(36'h8_0000_0000), 0, 1, 2'd1, 0)));
    s.push_back(mk(0, 1, 36'h0_0000_0007, 0, 1, ev(fl_of(36'h7), 1, 0, 2'd1, 0)));
    s.push_back(mk(0, 0, 36'h0, 0, 1, ev(fl_of(36'h7), 1, 0, 2'd0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL issue_with_wb step=%0d got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_flush_err();
    step_t s[$];
    logic [10:0] got, want;
    s.push_back(mk(1, 0, 36'h0, 0, 0, ev(fl_of(36'h7), 1, 0, 2'd0, 0)));
    s.push_back(mk(1, 0, 36'h0, 0, 0, ev(fl_of(36'h7), 0, 0, 2'd1, 0)));
    s.push_back(mk(1, 0, 36'h0, 0, 0, ev(fl_of(36'h7), 0, 0, 2'd2, 0)));
    s.push_back(mk(1, 0, 36'h0, 0, 1, ev(fl_of(36'h7), 0, 1, 2'd3, 0)));
    s.push_back(mk(0, 0, 36'h0, 1, 1, ev(fl_of(36'h7), 0, 1, 2'd3, 1)));
    s.push_back(mk(0, 0, 36'h0, 0, 1, ev(fl_of(36'h7), 1, 0, 2'd0, 1)));
    s.push_back(mk(0, 1, 36'h0, 0, 1, ev(fl_of(36'h7), 1, 0, 2'd0, 1)));
    s.push_back(mk(0, 0, 36'h0, 0, 1, ev(fl_of(36'h0), 1, 0, 2'd0, 1)));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL full_flush_err step=%0d got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    step_t s[$];
    logic [10:0] got, want;
    do_reset();
    s.push_back(mk(1, 0, 36'h0, 0, 0, ev(fl_of(36'h0), 1, 0, 2'd0, 0)));
    s.push_back(mk(1, 0, 36'h0, 0, 0, ev(fl_of(36'h0), 0, 0, 2'd1, 0)));
    s.push_back(mk(1, 1, 36'hA_0000_0001, 0, 0, ev(fl_of(36'h0), 0, 0, 2'd2, 0)));
    s.push_back(mk(0, 0, 36'h0, 0, 1, ev(fl_of(36'hA_0000_0001), 0, 1, 2'd2, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = observed();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL async_reset_setup step=%0d got=%b want=%b", i, got, want);
      end
      if (i < s.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    // Still between edges: pull reset and look before the next rising edge.
    #1 rst_n = 1'b0;
    exp_q.push_back(ev(fl_of(36'h0), 1, 0, 2'd0, 0));
    #1;
    got = observed();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL async_reset_clear got=%b want=%b", got, want);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_forward();
    test_back_to_back();
    test_issue_with_wb();
    test_full_flush_err();
    test_async_reset();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/condition_flag_unit.md
# condition_flag_unit

Holds the architectural condition flags (nz, ez, lz, gz, le, ge) that the branch/jump decode logic consumes. It derives the flags from the signed 36-bit ALU writeback result and tracks flag-setting instructions still in flight between decode and writeback. When the decode stage presents a conditional branch, the unit either supplies valid flags, forwarded from the same-cycle writeback when possible, or raises a stall. It sits between the execute/writeback stage and the branch/jump decoder.

## Interface
- DATA_W, 36, width of the writeback result
- MAX_INFLIGHT, 3, maximum flag-setting instructions in flight (counter saturates here)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_setflags  in  1  decode issued an instruction that will write flags this cycle
- wb_valid  in  1  writeback stage holds a valid result this cycle
- wb_setflags  in  1  the writeback instruction updates flags (ignored unless wb_valid)
- wb_result  in  DATA_W  writeback result, signed two's complement
- flush  in  1  squash all younger in-flight flag-setting instructions
- br_query  in  1  decode holds a conditional branch needing flags
- nz, ez, lz, gz, le, ge  out  1 each  flags for the branch decoder (registered or forwarded)
- flags_ready  out  1  flag outputs are valid for the querying branch
- stall  out  1  br_query & ~flags_ready
- pending  out  $clog2(MAX_INFLIGHT+1)  in-flight flag-setter count (debug/verif)
- err  out  1  sticky protocol error

## Operation
- Flag derivation from value r (signed): ez = (r==0), nz = ~ez, lz = r[DATA_W-1], gz = ~lz & nz, le = lz | ez, ge = ~lz.
- Flag register: on rising edge with wb_valid & wb_setflags, latch flags of wb_result. Otherwise hold.
- Pending counter: +1 on issue_setflags, −1 on wb_valid & wb_setflags, unchanged when both happen.
- States from the counter: IDLE (0), PENDING (1..MAX_INFLIGHT−1), FULL (MAX_INFLIGHT).
- flags_ready = (pending==0) | (pending==1 & wb_valid & wb_setflags).
- Forwarding: when pending==1 and a flag writeback occurs this cycle, the outputs show flags of wb_result combinationally. Otherwise they show the flag register.
- flags_ready is based on pending before this cycle's issue. An issue in the same cycle as br_query does not block that query.
- With pending≥2, a writeback does not make flags ready, because a younger setter is still outstanding.
- flush: pending becomes 0 next edge, overriding issue and decrement. A flag writeback in the flush cycle is from an older instruction and still updates the flag register.
- Error cases set err, which stays set until reset:
  - Issue in FULL without a simultaneous writeback: counter saturates.
  - Flag writeback with pending==0 and no simultaneous issue: counter stays 0 and the flag register still updates.
- stall is purely combinational and is 0 whenever br_query is 0.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): flag register = flags of 0, so ez=1, le=1, ge=1, nz=0, lz=0, gz=0. pending=0, err=0, flags_ready=1, stall=0.
- Reset mid-operation clears pending and the flags immediately, regardless of clk.
- Writeback to registered flags: 1 cycle. Writeback to forwarded flags: 0 cycles, same-cycle combinational.
- Issue to counter visible: 1 cycle.
- Outputs have no registered latency beyond the flag register and counter. No internal pipeline.

## Test plan
- Reset then br_query=1 -> flags_ready=1, stall=0, ez=1 le=1 ge=1 nz=lz=gz=0.
- issue_setflags for 1 cycle, then br_query held. Writeback wb_result=36'h0_0000_0005 two cycles later -> stall=1 until the wb cycle. In the wb cycle stall=0 with forwarded gz=1 nz=1 ge=1. Next cycle the registered flags match.
- Two issues back-to-back, then writebacks of 36'hF_FFFF_FFFF (−1) and 0 -> stall stays high through the first wb (pending 2→1). Released on the second wb with ez=1 le=1 ge=1.
- Issue and wb together at pending=1 -> pending remains 1, flags_ready=1 in that cycle via forwarding, err=0.
- Three issues (FULL) then a fourth with no wb -> pending=3, err=1 and sticky. flush next cycle -> pending=0, flags_ready=1, err still 1. A wb with pending 0 updates flags and keeps err=1.
- Assert rst_n low mid-cycle with pending=2 and lz=1 -> outputs return to reset values before the next edge.
